// File: rtl/fifo_ptr_ctrl_pkg.sv
// Shared constants and helpers for the FIFO pointer controller.
package fifo_ptr_ctrl_pkg;

  localparam int unsigned ADDR_WIDTH_MIN = 2;
  localparam int unsigned ADDR_WIDTH_MAX = 16;

  function automatic int unsigned fifo_depth(input int unsigned addr_width);
    return 32'd1 << addr_width;
  endfunction

endpackage

// File: rtl/bin_2_gray.sv
// Combinational binary-to-Gray converter.
module bin_2_gray #(
  parameter int WIDTH = 5
) (
  input  logic [WIDTH-1:0] bin_i,
  output logic [WIDTH-1:0] gray_o
);

  assign gray_o = bin_i ^ (bin_i >> 1);

endmodule

// File: rtl/fifo_ptr_ctrl_gray_ptr_cnt.sv
// Binary pointer counter with a Gray register loaded from the next binary value.
module gray_ptr_cnt #(
  parameter int WIDTH = 5
) (
  input  logic             clk_i,
  input  logic             arst_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] bin_o,
  output logic [WIDTH-1:0] gray_o
);

  logic [WIDTH-1:0] bin_q;
  logic [WIDTH-1:0] bin_d;
  logic [WIDTH-1:0] gray_q;
  logic [WIDTH-1:0] gray_d;

  always_comb begin
    bin_d = bin_q;
    if (clr_i) begin
      bin_d = '0;
    end else if (inc_i) begin
      bin_d = bin_q + WIDTH'(1);
    end
  end

  // Converting the next value keeps the Gray register aligned with bin_q.
  bin_2_gray #(
    .WIDTH(WIDTH)
  ) u_bin_2_gray (
    .bin_i (bin_d),
    .gray_o(gray_d)
  );

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      bin_q  <= '0;
      gray_q <= '0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
    end
  end

  assign bin_o  = bin_q;
  assign gray_o = gray_q;

endmodule

// File: rtl/fifo_ptr_ctrl.sv
// Single-clock FIFO pointer/flag controller: acceptance, RAM addresses,
// occupancy status and registered Gray pointers.
module fifo_ptr_ctrl
  import fifo_ptr_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 4
) (
  input  logic                clk_i,
  input  logic                arst_i,
  input  logic                flush_i,
  input  logic                wr_req_i,
  input  logic                rd_req_i,
  output logic                wr_en_o,
  output logic                rd_en_o,
  output logic [ADDR_WIDTH-1:0] wr_addr_o,
  output logic [ADDR_WIDTH-1:0] rd_addr_o,
  output logic [ADDR_WIDTH:0]   wr_ptr_gray_o,
  output logic [ADDR_WIDTH:0]   rd_ptr_gray_o,
  output logic [ADDR_WIDTH:0]   count_o,
  output logic                full_o,
  output logic                empty_o,
  output logic                overflow_o,
  output logic                underflow_o
);

  localparam int unsigned DEPTH = fifo_depth(ADDR_WIDTH);
  localparam logic [ADDR_WIDTH:0] DepthCount = (ADDR_WIDTH+1)'(DEPTH);

  logic [ADDR_WIDTH:0] wr_ptr;
  logic [ADDR_WIDTH:0] rd_ptr;
  logic                overflow_q;
  logic                underflow_q;
  logic                overflow_d;
  logic                underflow_d;

  gray_ptr_cnt #(
    .WIDTH(ADDR_WIDTH + 1)
  ) u_wr_ptr (
    .clk_i (clk_i),
    .arst_i(arst_i),
    .clr_i (flush_i),
    .inc_i (wr_en_o),
    .bin_o (wr_ptr),
    .gray_o(wr_ptr_gray_o)
  );

  gray_ptr_cnt #(
    .WIDTH(ADDR_WIDTH + 1)
  ) u_rd_ptr (
    .clk_i (clk_i),
    .arst_i(arst_i),
    .clr_i (flush_i),
    .inc_i (rd_en_o),
    .bin_o (rd_ptr),
    .gray_o(rd_ptr_gray_o)
  );

  // Status depends on the pointer registers only, never on this cycle's requests.
  assign count_o   = wr_ptr - rd_ptr;
  assign empty_o   = (wr_ptr == rd_ptr);
  assign full_o    = (count_o == DepthCount);
  assign wr_addr_o = wr_ptr[ADDR_WIDTH-1:0];
  assign rd_addr_o = rd_ptr[ADDR_WIDTH-1:0];

  assign wr_en_o = wr_req_i & ~full_o & ~flush_i;
  assign rd_en_o = rd_req_i & ~empty_o & ~flush_i;

  assign overflow_d  = wr_req_i & full_o & ~flush_i;
  assign underflow_d = rd_req_i & empty_o & ~flush_i;

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow_o  = overflow_q;
  assign underflow_o = underflow_q;

endmodule

// File: tb/tb_fifo_ptr_ctrl.sv
// Directed and randomized bench for fifo_ptr_ctrl against an occupancy model.
module tb_fifo_ptr_ctrl;

  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int PMOD  = 32;

  logic       clk = 1'b0;
  logic       arst = 1'b0;
  logic       flush = 1'b0;
  logic       wrReq = 1'b0;
  logic       rdReq = 1'b0;
  logic       wrEn;
  logic       rdEn;
  logic [3:0] wrAddr;
  logic [3:0] rdAddr;
  logic [4:0] wrGray;
  logic [4:0] rdGray;
  logic [4:0] count;
  logic       full;
  logic       empty;
  logic       overflow;
  logic       underflow;

  int tests = 0;
  int fails = 0;

  // Reference model: plain write/read totals modulo 2*DEPTH.
  int mWr = 0;
  int mRd = 0;
  int mOvf = 0;
  int mUdf = 0;

  fifo_ptr_ctrl #(
    .ADDR_WIDTH(AW)
  ) dut (
    .clk_i        (clk),
    .arst_i       (arst),
    .flush_i      (flush),
    .wr_req_i     (wrReq),
    .rd_req_i     (rdReq),
    .wr_en_o      (wrEn),
    .rd_en_o      (rdEn),
    .wr_addr_o    (wrAddr),
    .rd_addr_o    (rdAddr),
    .wr_ptr_gray_o(wrGray),
    .rd_ptr_gray_o(rdGray),
    .count_o      (count),
    .full_o       (full),
    .empty_o      (empty),
    .overflow_o   (overflow),
    .underflow_o  (underflow)
  );

  always #5 clk = ~clk;

  function automatic int mCount();
    return (mWr - mRd + PMOD) % PMOD;
  endfunction

  function automatic int toGray(input int b);
    return b ^ (b >> 1);
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string where);
    check({where, " count"}, int'(count), mCount());
    check({where, " full"}, int'(full), (mCount() == DEPTH) ? 1 : 0);
    check({where, " empty"}, int'(empty), (mCount() == 0) ? 1 : 0);
    check({where, " wr_addr"}, int'(wrAddr), mWr % DEPTH);
    check({where, " rd_addr"}, int'(rdAddr), mRd % DEPTH);
    check({where, " wr_gray"}, int'(wrGray), toGray(mWr));
    check({where, " rd_gray"}, int'(rdGray), toGray(mRd));
    check({where, " overflow"}, int'(overflow), mOvf);
    check({where, " underflow"}, int'(underflow), mUdf);
  endtask

  // One clock cycle: drive, check acceptance, advance model, check state.
  task automatic applyStimulus(input string where, input logic wr, input logic rd,
                               input logic fl);
    int  cnt;
    int  expWrEn;
    int  expRdEn;
    logic [4:0] prevWrGray;
    logic [4:0] prevRdGray;
    @(negedge clk);
    wrReq = wr;
    rdReq = rd;
    flush = fl;
    #1;
    cnt     = mCount();
    expWrEn = (wr && cnt != DEPTH && !fl) ? 1 : 0;
    expRdEn = (rd && cnt != 0 && !fl) ? 1 : 0;
    check({where, " wr_en"}, int'(wrEn), expWrEn);
    check({where, " rd_en"}, int'(rdEn), expRdEn);
    prevWrGray = wrGray;
    prevRdGray = rdGray;
    @(posedge clk);
    mOvf = (wr && cnt == DEPTH && !fl) ? 1 : 0;
    mUdf = (rd && cnt == 0 && !fl) ? 1 : 0;
    if (fl) begin
      mWr = 0;
      mRd = 0;
    end else begin
      mWr = (mWr + expWrEn) % PMOD;
      mRd = (mRd + expRdEn) % PMOD;
    end
    #1;
    checkOutput(where);
    if (!fl && expWrEn == 1)
      check({where, " wr_gray onebit"}, $countones(prevWrGray ^ wrGray), 1);
    if (!fl && expRdEn == 1)
      check({where, " rd_gray onebit"}, $countones(prevRdGray ^ rdGray), 1);
  endtask

  task automatic modelReset();
    mWr  = 0;
    mRd  = 0;
    mOvf = 0;
    mUdf = 0;
  endtask

  initial begin
    // Reset asserted away from any edge takes effect without a clock.
    #2;
    arst = 1'b1;
    modelReset();
    #1;
    checkOutput("reset");
    @(negedge clk);
    arst = 1'b0;

    // Fill to full, then one rejected write.
    for (int i = 0; i < DEPTH; i++) applyStimulus("fill", 1'b1, 1'b0, 1'b0);
    applyStimulus("write at full", 1'b1, 1'b0, 1'b0);
    check("wr_gray at 16", int'(wrGray), 24);
    applyStimulus("idle after overflow", 1'b0, 1'b0, 1'b0);

    // Drain, then one rejected read.
    for (int i = 0; i < DEPTH; i++) applyStimulus("drain", 1'b0, 1'b1, 1'b0);
    applyStimulus("read at empty", 1'b0, 1'b1, 1'b0);
    applyStimulus("idle after underflow", 1'b0, 1'b0, 1'b0);

    // Simultaneous requests at full and at empty.
    for (int i = 0; i < DEPTH; i++) applyStimulus("refill", 1'b1, 1'b0, 1'b0);
    applyStimulus("both at full", 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < DEPTH - 1; i++) applyStimulus("redrain", 1'b0, 1'b1, 1'b0);
    applyStimulus("both at empty", 1'b1, 1'b1, 1'b0);
    applyStimulus("empty again", 1'b0, 1'b1, 1'b0);

    // Paired traffic walks both pointers through several wraps.
    for (int i = 0; i < 64; i++) applyStimulus("wrap sweep", 1'b1, 1'b1, 1'b0);

    // Flush with both requests at count 7.
    applyStimulus("pre flush", 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) applyStimulus("to seven", 1'b1, 1'b0, 1'b0);
    check("count seven", int'(count), 7);
    applyStimulus("flush with reqs", 1'b1, 1'b1, 1'b1);
    applyStimulus("after flush", 1'b0, 1'b0, 1'b0);

    // Same scenario interrupted by asynchronous reset mid-cycle.
    for (int i = 0; i < 7; i++) applyStimulus("to seven again", 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    wrReq = 1'b1;
    rdReq = 1'b1;
    #2;
    arst = 1'b1;
    modelReset();
    #1;
    checkOutput("async reset mid-op");
    @(negedge clk);
    arst  = 1'b0;
    wrReq = 1'b0;
    rdReq = 1'b0;
    applyStimulus("first after reset", 1'b1, 1'b0, 1'b0);

    // Randomized traffic with occasional flushes.
    for (int i = 0; i < 400; i++) begin
      applyStimulus("random", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 31) == 0) ? 1'b1 : 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
